operand_collector: RTL and testbench

- Upstream feeder for the four-operand maximum-finder top (X1..X4, start_signal, done, 5-bit maximum).
- Accepts a serial stream of WIDTH-bit operands over a valid/ready handshake and buffers them into four slots.
- Fires a one-cycle start pulse to the max core, holds X1..X4 stable while it runs, then captures the core's maximum and reports it with a one-cycle valid strobe.
- Keeps a running batch counter.

---
 rtl/operand_collector_pkg.sv | 24 ++
 rtl/operand_collector_slot_buffer.sv | 45 ++++
 rtl/operand_collector.sv | 110 +++++++++++
 tb/tb_operand_collector.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/operand_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : operand_collector_pkg
//  Brief    : Shared state encoding and slot constants for the operand
//             collector and its slot buffer.
//  Revision : 1.0  initial release
// ============================================================================
package operand_collector_pkg;

   // Collector FSM states
   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   // Number of operand slots feeding the max core
   localparam int NUM_SLOTS = 4;

   // Index of the final slot; filling it completes a batch
   localparam logic [1:0] LAST_SLOT_IDX = 2'(NUM_SLOTS - 1);

endpackage : operand_collector_pkg
`default_nettype wire

// File: rtl/operand_collector_slot_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : operand_slot_buffer
//  Brief    : Four WIDTH-bit operand registers written one at a time by a
//             2-bit index. Contents are held until overwritten or reset.
//  Revision : 1.0  initial release
// ============================================================================
module operand_slot_buffer
   import operand_collector_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,        // synchronous, active-low
   input  logic             wr_en_i,
   input  logic [1:0]       wr_idx_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic [WIDTH-1:0] slot0_o,
   output logic [WIDTH-1:0] slot1_o,
   output logic [WIDTH-1:0] slot2_o,
   output logic [WIDTH-1:0] slot3_o
);

   logic [WIDTH-1:0] slots_q [NUM_SLOTS];

   generate
      for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
         // Each slot captures the incoming operand only when addressed
         always_ff @(posedge clk) begin
            if (!rst) begin
               slots_q[i] <= '0;
            end else if (wr_en_i && (wr_idx_i == 2'(i))) begin
               slots_q[i] <= wr_data_i;
            end
         end
      end
   endgenerate

   assign slot0_o = slots_q[0];
   assign slot1_o = slots_q[1];
   assign slot2_o = slots_q[2];
   assign slot3_o = slots_q[3];

endmodule : operand_slot_buffer
`default_nettype wire

// File: rtl/operand_collector.sv
`default_nettype none
// ============================================================================
//  Module   : operand_collector
//  Brief    : Buffers a serial valid/ready operand stream into four slots,
//             launches the max core with a one-cycle start pulse, captures
//             its maximum on the rising edge of done and counts batches.
//  Revision : 1.0  initial release
// ============================================================================
module operand_collector
   import operand_collector_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,          // synchronous, active-low
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic [WIDTH-1:0] X1,
   output logic [WIDTH-1:0] X2,
   output logic [WIDTH-1:0] X3,
   output logic [WIDTH-1:0] X4,
   output logic             start_signal,
   input  logic             core_done,
   input  logic [4:0]       core_max,
   output logic [4:0]       result,
   output logic             result_valid,
   output logic [CNT_W-1:0] batch_count
);

   state_e           state_q;
   logic [1:0]       idx_q;
   logic             done_q;
   logic             start_q;
   logic [4:0]       result_q;
   logic             result_valid_q;
   logic [CNT_W-1:0] batch_count_q;

   logic             accept;
   logic             done_rise;

   assign in_ready  = (state_q == ST_FILL);
   assign accept    = in_valid && in_ready;
   // Only a fresh rising edge ends a run; a level left high is ignored
   assign done_rise = core_done && !done_q;

   operand_slot_buffer #(
      .WIDTH (WIDTH)
   ) u_slots (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (accept),
      .wr_idx_i  (idx_q),
      .wr_data_i (in_data),
      .slot0_o   (X1),
      .slot1_o   (X2),
      .slot2_o   (X3),
      .slot3_o   (X4)
   );

   // Collector FSM with registered start/result strobes and batch counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= ST_FILL;
         idx_q          <= 2'd0;
         done_q         <= 1'b0;
         start_q        <= 1'b0;
         result_q       <= 5'd0;
         result_valid_q <= 1'b0;
         batch_count_q  <= '0;
      end else begin
         done_q         <= core_done;
         start_q        <= 1'b0;
         result_valid_q <= 1'b0;
         case (state_q)
            ST_FILL: begin
               if (in_valid) begin
                  idx_q <= idx_q + 2'd1;
                  if (idx_q == LAST_SLOT_IDX) begin
                     state_q <= ST_START;
                     start_q <= 1'b1;
                  end
               end
            end
            ST_START: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (done_rise) begin
                  result_q       <= core_max;
                  result_valid_q <= 1'b1;
                  batch_count_q  <= batch_count_q + CNT_W'(1);
                  state_q        <= ST_FILL;
               end
            end
            default: begin
               state_q <= ST_FILL;
            end
         endcase
      end
   end

   assign start_signal = start_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign batch_count  = batch_count_q;

endmodule : operand_collector
`default_nettype wire

// File: tb/tb_operand_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_collector
//  Brief    : Directed self-checking bench for operand_collector.
//  Revision : 1.0  initial release
// ============================================================================
module tb_operand_collector;

   localparam int WIDTH = 5;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ready;
   logic [WIDTH-1:0] X1, X2, X3, X4;
   logic             start_signal;
   logic             core_done = 1'b0;
   logic [4:0]       core_max = 5'd0;
   logic [4:0]       result;
   logic             result_valid;
   logic [CNT_W-1:0] batch_count;

   int errors = 0;
   int checks = 0;
   int start_cnt = 0;
   int accept_cnt = 0;

   operand_collector #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .X1           (X1),
      .X2           (X2),
      .X3           (X3),
      .X4           (X4),
      .start_signal (start_signal),
      .core_done    (core_done),
      .core_max     (core_max),
      .result       (result),
      .result_valid (result_valid),
      .batch_count  (batch_count)
   );

   always #5 clk = ~clk;

   // Observe handshake transfers and start pulses at the clock edge
   always @(posedge clk) begin
      if (in_valid && in_ready) accept_cnt <= accept_cnt + 1;
      if (start_signal)         start_cnt  <= start_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic feed(input logic [WIDTH-1:0] v);
      in_valid = 1'b1;
      in_data  = v;
      tick();
      in_valid = 1'b0;
   endtask

   // Feed four operands, let the core answer after a few cycles, check result
   task automatic run_batch(input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c, input logic [4:0] d,
                            input logic [4:0] mx, input logic [CNT_W-1:0] exp_cnt);
      feed(a); feed(b); feed(c); feed(d);
      tick();                        // now WAIT
      core_done = 1'b1;
      core_max  = mx;
      tick();
      check("wrap_result", result, mx);
      check("wrap_count", batch_count, exp_cnt);
      core_done = 1'b0;
   endtask

   initial begin
      // ---------------- reset / idle ----------------
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      check("rst_in_ready", in_ready, 1);
      check("rst_X1", X1, 0);
      check("rst_X2", X2, 0);
      check("rst_X3", X3, 0);
      check("rst_X4", X4, 0);
      check("rst_start", start_signal, 0);
      check("rst_rv", result_valid, 0);
      check("rst_result", result, 0);
      check("rst_count", batch_count, 0);
      tick();
      check("idle_in_ready", in_ready, 1);
      check("idle_start", start_signal, 0);

      // ---------------- basic batch 3,17,9,30 ----------------
      start_cnt = 0;
      feed(5'd3); feed(5'd17); feed(5'd9);
      check("basic_no_early_start", start_signal, 0);
      feed(5'd30);
      check("basic_start_pulse", start_signal, 1);
      check("basic_ready_start", in_ready, 0);
      tick();
      check("basic_start_low", start_signal, 0);
      check("basic_ready_wait", in_ready, 0);
      for (int i = 0; i < 4; i++) begin
         check("basic_X1", X1, 3);
         check("basic_X2", X2, 17);
         check("basic_X3", X3, 9);
         check("basic_X4", X4, 30);
         check("basic_rv_wait", result_valid, 0);
         tick();
      end
      core_done = 1'b1;              // 5 cycles after start
      core_max  = 5'd30;
      tick();
      check("basic_rv", result_valid, 1);
      check("basic_result", result, 30);
      check("basic_count", batch_count, 1);
      check("basic_ready_after", in_ready, 1);
      check("basic_start_once", start_cnt, 1);
      tick();
      check("basic_rv_single", result_valid, 0);
      check("basic_result_hold", result, 30);

      // ---------------- sticky done: batch 5,6,7,8 ----------------
      // core_done left high from the previous run
      feed(5'd5); feed(5'd6); feed(5'd7); feed(5'd8);
      check("sticky_start", start_signal, 1);
      core_max = 5'd8;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("sticky_hold_wait", in_ready, 0);
         check("sticky_no_rv", result_valid, 0);
      end
      core_done = 1'b0;
      tick(); tick();
      check("sticky_still_wait", in_ready, 0);
      check("sticky_count_hold", batch_count, 1);
      core_done = 1'b1;
      tick();
      check("sticky_rv", result_valid, 1);
      check("sticky_result", result, 8);
      check("sticky_count", batch_count, 2);
      core_done = 1'b0;

      // ---------------- gapped input / backpressure ----------------
      accept_cnt = 0;
      feed(5'd1); tick(); tick();
      feed(5'd31); tick();
      feed(5'd0); tick(); tick(); tick();
      check("gap_ready_fill", in_ready, 1);
      check("gap_no_start", start_signal, 0);
      feed(5'd12);
      check("gap_start", start_signal, 1);
      in_valid = 1'b1;               // held during START/WAIT
      in_data  = 5'd7;
      tick();
      check("gap_ready_wait", in_ready, 0);
      tick(); tick();
      check("gap_X1", X1, 1);
      check("gap_X2", X2, 31);
      check("gap_X3", X3, 0);
      check("gap_X4", X4, 12);
      core_done = 1'b1;
      core_max  = 5'd31;
      tick();
      in_valid = 1'b0;
      check("gap_accepts", accept_cnt, 4);
      check("gap_rv", result_valid, 1);
      check("gap_result", result, 31);
      check("gap_count", batch_count, 3);
      core_done = 1'b0;

      // ---------------- reset mid-operation ----------------
      feed(5'd21); feed(5'd22);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("mid_X1", X1, 0);
      check("mid_X2", X2, 0);
      check("mid_ready", in_ready, 1);
      check("mid_result", result, 0);
      check("mid_count", batch_count, 0);
      check("mid_start", start_signal, 0);
      feed(5'd4); feed(5'd4); feed(5'd4);
      check("mid_no_early_start", start_signal, 0);
      feed(5'd4);
      check("mid_start_pulse", start_signal, 1);
      tick(); tick();
      check("mid_X1_new", X1, 4);
      check("mid_X4_new", X4, 4);
      core_done = 1'b1;
      core_max  = 5'd4;
      tick();
      check("mid_rv", result_valid, 1);
      check("mid_result_new", result, 4);
      check("mid_count_new", batch_count, 1);
      core_done = 1'b0;

      // ---------------- counter wrap (CNT_W=2) ----------------
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("wrap_reset_count", batch_count, 0);
      tick();
      run_batch(5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 2'd1);
      run_batch(5'd9, 5'd8, 5'd7, 5'd6, 5'd9, 2'd2);
      run_batch(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd3);
      run_batch(5'd31, 5'd1, 5'd1, 5'd1, 5'd31, 2'd0);
      run_batch(5'd2, 5'd20, 5'd11, 5'd19, 5'd20, 2'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_operand_collector
`default_nettype wire
